// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer for the motion-estimation engine: walks macroblocks in raster
// order, drives fetches, starts and watchdogs the engine, and emits one MV per MB.
module me_frame_scheduler #(
  parameter int FRAME_W_MB = 22,
  parameter int FRAME_H_MB = 18,
  parameter int MV_OFFSET  = 16,
  parameter int TIMEOUT    = 2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       frame_abort,
  output logic       fetch_req,
  output logic       fetch_type,
  output logic [4:0] fetch_mb_x,
  output logic [4:0] fetch_mb_y,
  output logic [3:0] fetch_edge,
  input  logic       fetch_ack,
  output logic       me_start,
  output logic       me_stop,
  input  logic       me_done,
  input  logic [9:0] best_idx,
  output logic       mv_valid,
  input  logic       mv_ready,
  output logic [5:0] mv_x,
  output logic [5:0] mv_y,
  output logic [4:0] mv_mb_x,
  output logic [4:0] mv_mb_y,
  output logic       mv_err,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] dbg_state
);

  // MV port handshake: mv_valid rises with the data and holds it unchanged until a
  // cycle with mv_valid & mv_ready; the transfer happens on that clock edge.
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_CUR, S_FETCH_SW, S_START, S_RUN, S_EMIT, S_ADVANCE
  } state_t;

  localparam int TW = $clog2(TIMEOUT);

  state_t        state, state_n;
  logic [4:0]    mb_x, mb_y, mb_x_n, mb_y_n;
  logic [TW-1:0] timer, timer_n;
  logic          stopped, stopped_n;
  logic          req_q, req_n;
  logic          me_done_d, done_edge;
  logic [5:0]    mvx_q, mvy_q, mvx_n, mvy_n;
  logic [4:0]    mvmx_q, mvmy_q, mvmx_n, mvmy_n;
  logic          err_q, err_n;
  logic          last_x, last_y;

  assign done_edge = me_done & ~me_done_d;
  assign last_x    = (mb_x == 5'(FRAME_W_MB - 1));
  assign last_y    = (mb_y == 5'(FRAME_H_MB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mb_x      <= '0;
      mb_y      <= '0;
      timer     <= '0;
      stopped   <= 1'b0;
      req_q     <= 1'b0;
      me_done_d <= 1'b0;
      mvx_q     <= '0;
      mvy_q     <= '0;
      mvmx_q    <= '0;
      mvmy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      mb_x      <= mb_x_n;
      mb_y      <= mb_y_n;
      timer     <= timer_n;
      stopped   <= stopped_n;
      req_q     <= req_n;
      me_done_d <= me_done;
      mvx_q     <= mvx_n;
      mvy_q     <= mvy_n;
      mvmx_q    <= mvmx_n;
      mvmy_q    <= mvmy_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    mb_x_n     = mb_x;
    mb_y_n     = mb_y;
    timer_n    = timer;
    stopped_n  = stopped;
    mvx_n      = mvx_q;
    mvy_n      = mvy_q;
    mvmx_n     = mvmx_q;
    mvmy_n     = mvmy_q;
    err_n      = err_q;
    me_start   = 1'b0;
    me_stop    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: if (frame_start) begin
        state_n = S_FETCH_CUR;
        mb_x_n  = '0;
        mb_y_n  = '0;
      end
      S_FETCH_CUR: if (req_q && fetch_ack) state_n = S_FETCH_SW;
      S_FETCH_SW:  if (req_q && fetch_ack) state_n = S_START;
      S_START: begin
        me_start  = 1'b1;
        timer_n   = '0;
        stopped_n = 1'b0;
        mvmx_n    = mb_x;
        mvmy_n    = mb_y;
        state_n   = S_RUN;
      end
      S_RUN: begin
        // A done level left over from the previous MB is not a completion.
        if (done_edge) begin
          mvx_n   = {1'b0, best_idx[9:5]} - 6'(MV_OFFSET);
          mvy_n   = {1'b0, best_idx[4:0]} - 6'(MV_OFFSET);
          err_n   = stopped;
          state_n = S_EMIT;
        end else if (!stopped) begin
          if (timer == TW'(TIMEOUT - 1)) begin
            me_stop   = 1'b1;
            stopped_n = 1'b1;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
      end
      S_EMIT: if (mv_ready) state_n = S_ADVANCE;
      S_ADVANCE: begin
        if (!last_x) begin
          mb_x_n  = mb_x + 5'd1;
          state_n = S_FETCH_CUR;
        end else if (!last_y) begin
          mb_x_n  = '0;
          mb_y_n  = mb_y + 5'd1;
          state_n = S_FETCH_CUR;
        end else begin
          mb_x_n     = '0;
          mb_y_n     = '0;
          frame_done = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (frame_abort && state != S_IDLE) begin
      state_n    = S_IDLE;
      me_start   = 1'b0;
      frame_done = 1'b0;
      me_stop    = (state == S_RUN);
    end
  end

  // Request is registered so it drops for one cycle after every ack, even across
  // the current-block to search-window change.
  always_comb begin
    req_n = ((state_n == S_FETCH_CUR) || (state_n == S_FETCH_SW)) && !(req_q && fetch_ack);
  end

  assign fetch_req  = req_q;
  assign fetch_type = req_q & (state == S_FETCH_SW);
  assign fetch_mb_x = req_q ? mb_x : 5'd0;
  assign fetch_mb_y = req_q ? mb_y : 5'd0;
  assign fetch_edge = req_q ? {mb_x == 5'd0, last_x, mb_y == 5'd0, last_y} : 4'd0;
  assign mv_valid   = (state == S_EMIT);
  assign mv_x       = mv_valid ? mvx_q : 6'd0;
  assign mv_y       = mv_valid ? mvy_q : 6'd0;
  assign mv_mb_x    = mv_valid ? mvmx_q : 5'd0;
  assign mv_mb_y    = mv_valid ? mvmy_q : 5'd0;
  assign mv_err     = mv_valid & err_q;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Bench for me_frame_scheduler on a 2x2-MB frame: fetch/edge vectors, MV scoreboard,
// back-pressure, watchdog stop, abort and mid-frame reset.
module tb_me_frame_scheduler;
  localparam int W = 2, H = 2, OFF = 16, TO = 64;

  logic       clk = 1'b0, reset = 1'b1;
  logic       frame_start = 1'b0, frame_abort = 1'b0, fetch_ack = 1'b0;
  logic       me_done = 1'b0, mv_ready = 1'b1;
  logic [9:0] best_idx = '0;
  logic       fetch_req, fetch_type, me_start, me_stop, mv_valid, mv_err, busy, frame_done;
  logic [4:0] fetch_mb_x, fetch_mb_y, mv_mb_x, mv_mb_y;
  logic [3:0] fetch_edge;
  logic [5:0] mv_x, mv_y;
  logic [2:0] dbg_state;

  int n_checks = 0, n_err = 0, frame_done_cnt = 0;
  logic [22:0] exp_q[$];
  logic [22:0] got_rec, exp_rec;

  typedef struct {
    logic [9:0] best;
    logic [5:0] mvx, mvy;
    logic [3:0] edg;
    logic [4:0] mbx, mby;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  me_frame_scheduler #(.FRAME_W_MB(W), .FRAME_H_MB(H), .MV_OFFSET(OFF), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_abort(frame_abort),
    .fetch_req(fetch_req), .fetch_type(fetch_type), .fetch_mb_x(fetch_mb_x),
    .fetch_mb_y(fetch_mb_y), .fetch_edge(fetch_edge), .fetch_ack(fetch_ack),
    .me_start(me_start), .me_stop(me_stop), .me_done(me_done), .best_idx(best_idx),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_x(mv_x), .mv_y(mv_y),
    .mv_mb_x(mv_mb_x), .mv_mb_y(mv_mb_y), .mv_err(mv_err), .busy(busy),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {fetch_req, fetch_type, fetch_mb_x, fetch_mb_y, fetch_edge, me_start, me_stop,
            mv_valid, mv_x, mv_y, mv_mb_x, mv_mb_y, mv_err, busy, frame_done, dbg_state};
  endfunction

  // Scoreboard: sampled after the bench has driven this cycle's inputs, so a
  // valid & ready seen here is the transfer taken on the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (frame_done) frame_done_cnt++;
    if (mv_valid && mv_ready) begin
      got_rec = {mv_err, mv_mb_x, mv_mb_y, mv_x, mv_y};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL mv_unexpected: got %0h expected none", got_rec);
      end else begin
        exp_rec = exp_q.pop_front();
        check("mv_record", got_rec, exp_rec);
      end
    end
  end

  function automatic logic probe(input int which);
    case (which)
      0: return fetch_req;
      1: return me_start;
      2: return mv_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which);
    int n = 0;
    while (!probe(which) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, probe(which), 1);
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_fetch(input logic typ, input logic [4:0] x, input logic [4:0] y,
                          input logic [3:0] edg);
    wait_for("fetch_req", 0);
    check("fetch_type", fetch_type, typ);
    check("fetch_mb", {fetch_mb_x, fetch_mb_y}, {x, y});
    check("fetch_edge", fetch_edge, edg);
    repeat (2) @(negedge clk);
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    check("fetch_req_drop", fetch_req, 0);
  endtask

  // mode 0: normal, 1: consumer stalls 5 cycles, 2: engine hangs until watchdog
  task automatic run_mb(input vec_t v, input int mode);
    int n;
    do_fetch(1'b0, v.mbx, v.mby, v.edg);
    do_fetch(1'b1, v.mbx, v.mby, v.edg);
    wait_for("me_start", 1);
    if (mode == 2) begin
      n = 0;
      while (!me_stop && n < 300) begin
        @(negedge clk);
        n++;
        if (n == 2) me_done = 1'b0;
      end
      check("timeout_cycle", n, TO);
      @(negedge clk);
      check("me_stop_pulse", me_stop, 0);
    end else begin
      repeat (2) @(negedge clk);
      me_done = 1'b0;
      repeat (3) @(negedge clk);
    end
    if (mode == 1) mv_ready = 1'b0;
    best_idx = v.best;
    exp_q.push_back({(mode == 2), v.mbx, v.mby, v.mvx, v.mvy});
    me_done = 1'b1;
    wait_for("mv_valid", 2);
    if (mode == 1) begin
      repeat (5) begin
        check("hold_valid", mv_valid, 1);
        check("hold_mv", {mv_x, mv_y}, {v.mvx, v.mvy});
        check("hold_no_fetch", fetch_req, 0);
        @(negedge clk);
      end
      mv_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{10'h210, 6'h00, 6'h00, 4'b1010, 5'd0, 5'd0};
    vecs[1] = '{10'h01F, 6'h30, 6'h0F, 4'b0110, 5'd1, 5'd0};
    vecs[2] = '{10'h3E0, 6'h0F, 6'h30, 4'b1001, 5'd0, 5'd1};
    vecs[3] = '{10'h285, 6'h04, 6'h35, 4'b0101, 5'd1, 5'd1};

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_outputs(), 0);

    // Frame 1: raster walk with edge flags and a stalled consumer on MB(1,0)
    start_frame();
    for (int i = 0; i < 4; i++) run_mb(vecs[i], (i == 1) ? 1 : 0);
    repeat (3) @(negedge clk);
    check("frame_done_count1", frame_done_cnt, 1);
    check("idle_after_frame", busy, 0);

    // Frame 2: engine hangs on the first MB, frame then carries on
    start_frame();
    for (int i = 0; i < 4; i++) run_mb(vecs[i], (i == 0) ? 2 : 0);
    repeat (3) @(negedge clk);
    check("frame_done_count2", frame_done_cnt, 2);

    // Frame 3: abort while the engine runs
    start_frame();
    do_fetch(1'b0, 5'd0, 5'd0, 4'b1010);
    do_fetch(1'b1, 5'd0, 5'd0, 4'b1010);
    wait_for("me_start", 1);
    repeat (2) @(negedge clk);
    me_done = 1'b0;
    repeat (3) @(negedge clk);
    frame_abort = 1'b1;
    #1;
    check("abort_me_stop", me_stop, 1);
    @(negedge clk);
    frame_abort = 1'b0;
    check("abort_idle", {busy, fetch_req, mv_valid, me_stop}, 0);
    repeat (4) @(negedge clk);
    check("abort_no_frame_done", frame_done_cnt, 2);

    // Frame 4: asynchronous reset during the search-window fetch
    start_frame();
    do_fetch(1'b0, 5'd0, 5'd0, 4'b1010);
    wait_for("fetch_req", 0);
    check("sw_fetch_type", fetch_type, 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", all_outputs(), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_stays_idle", all_outputs(), 0);
    check("frame_done_total", frame_done_cnt, 2);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
